// File: rtl/reg_bank8_sb.sv
// Eight-entry architectural register bank with byte-lane write-back and an
// issue scoreboard that holds decode on read-after-write / write-after-write hazards.
module reg_bank8_sb #(
    parameter int DATA_WIDTH = 16,
    parameter bit ZERO_R0    = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [2:0]            wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic [1:0]            wb_be,
    output logic                  wb_spurious,
    input  logic                  iss_valid,
    input  logic [2:0]            iss_dst,
    input  logic                  iss_has_dst,
    input  logic [2:0]            iss_src_a,
    input  logic [2:0]            iss_src_b,
    input  logic                  iss_use_b,
    output logic                  iss_stall,
    output logic [7:0]            pending,
    output logic [DATA_WIDTH-1:0] r0_out,
    output logic [DATA_WIDTH-1:0] r1_out,
    output logic [DATA_WIDTH-1:0] r2_out,
    output logic [DATA_WIDTH-1:0] r3_out,
    output logic [DATA_WIDTH-1:0] r4_out,
    output logic [DATA_WIDTH-1:0] r5_out,
    output logic [DATA_WIDTH-1:0] r6_out,
    output logic [DATA_WIDTH-1:0] r7_out
);

    localparam int LANE_W = DATA_WIDTH / 2;

    logic [DATA_WIDTH-1:0] r_regs [8];
    logic [7:0]            r_pending;
    logic                  r_ready;
    logic                  r_spurious;

    logic                  w_wb_fire;
    logic                  w_wb_r0_null;
    logic                  w_iss_fire;
    logic                  w_iss_r0_null;
    logic                  w_stall;
    logic                  w_hazard_a;
    logic                  w_hazard_b;
    logic                  w_hazard_d;
    logic [7:0]            w_clear_mask;
    logic [7:0]            w_set_mask;
    logic [7:0]            w_pend_eff;
    logic [7:0]            w_pend_next;
    logic [DATA_WIDTH-1:0] w_lane_mask;
    logic [DATA_WIDTH-1:0] w_merged;

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        logic [7:0] v;
        v      = 8'h00;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [1:0] be);
        return {{LANE_W{be[1]}}, {LANE_W{be[0]}}};
    endfunction

    // Write-back side: a hardwired r0 swallows the write and never touches the scoreboard.
    always_comb begin
        w_wb_fire    = wb_valid & r_ready;
        w_wb_r0_null = ZERO_R0 && (wb_addr == 3'd0);
        w_clear_mask = (w_wb_fire && !w_wb_r0_null) ? onehot8(wb_addr) : 8'h00;
        w_lane_mask  = lane_mask(wb_be);
        w_merged     = (r_regs[wb_addr] & ~w_lane_mask) | (wb_data & w_lane_mask);
    end

    // Issue side: a same-cycle write-back already counts as resolved.
    always_comb begin
        w_pend_eff    = r_pending & ~w_clear_mask;
        w_hazard_a    = w_pend_eff[iss_src_a];
        w_hazard_b    = iss_use_b & w_pend_eff[iss_src_b];
        w_hazard_d    = iss_has_dst & w_pend_eff[iss_dst];
        w_stall       = iss_valid & (w_hazard_a | w_hazard_b | w_hazard_d);
        w_iss_fire    = iss_valid & ~w_stall & iss_has_dst;
        w_iss_r0_null = ZERO_R0 && (iss_dst == 3'd0);
        w_set_mask    = (w_iss_fire && !w_iss_r0_null) ? onehot8(iss_dst) : 8'h00;
        // Set is OR-ed after the clear so a new claim on the same register survives.
        w_pend_next   = w_pend_eff | w_set_mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready    <= 1'b0;
            r_pending  <= 8'h00;
            r_spurious <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_ready    <= 1'b1;
            r_pending  <= w_pend_next;
            r_spurious <= w_wb_fire & ~w_wb_r0_null & ~r_pending[wb_addr];
            if (w_wb_fire && !w_wb_r0_null) begin
                r_regs[wb_addr] <= w_merged;
            end
        end
    end

    assign wb_ready    = r_ready;
    assign wb_spurious = r_spurious;
    assign iss_stall   = w_stall;
    assign pending     = r_pending;

    assign r0_out = ZERO_R0 ? '0 : r_regs[0];
    assign r1_out = r_regs[1];
    assign r2_out = r_regs[2];
    assign r3_out = r_regs[3];
    assign r4_out = r_regs[4];
    assign r5_out = r_regs[5];
    assign r6_out = r_regs[6];
    assign r7_out = r_regs[7];

endmodule

// File: tb/tb_reg_bank8_sb.sv
// Scoreboard bench for reg_bank8_sb: two instances (ZERO_R0=0 and ZERO_R0=1)
// share directed stimulus; expectations are queued by cycle and checked at negedge.
module tb_reg_bank8_sb;

    localparam int S_PEND   = 8;
    localparam int S_READY  = 9;
    localparam int S_SPUR   = 10;
    localparam int S_STALL  = 11;
    localparam int S_B_R0   = 12;
    localparam int S_B_PEND = 13;
    localparam int S_B_SPUR = 14;
    localparam int S_B_STALL = 15;
    localparam int S_B_RDY  = 16;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [1:0]  wb_be;
    logic        iss_valid;
    logic [2:0]  iss_dst;
    logic        iss_has_dst;
    logic [2:0]  iss_src_a;
    logic [2:0]  iss_src_b;
    logic        iss_use_b;

    logic        a_ready, a_spur, a_stall;
    logic [7:0]  a_pend;
    logic [15:0] a_r [8];
    logic        b_ready, b_spur, b_stall;
    logic [7:0]  b_pend;
    logic [15:0] b_r [8];

    typedef struct {
        int          cyc;
        int          sel;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    reg_bank8_sb #(.DATA_WIDTH(16), .ZERO_R0(1'b0)) u_dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_ready(a_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_be(wb_be), .wb_spurious(a_spur),
        .iss_valid(iss_valid), .iss_dst(iss_dst), .iss_has_dst(iss_has_dst),
        .iss_src_a(iss_src_a), .iss_src_b(iss_src_b), .iss_use_b(iss_use_b),
        .iss_stall(a_stall), .pending(a_pend),
        .r0_out(a_r[0]), .r1_out(a_r[1]), .r2_out(a_r[2]), .r3_out(a_r[3]),
        .r4_out(a_r[4]), .r5_out(a_r[5]), .r6_out(a_r[6]), .r7_out(a_r[7])
    );

    reg_bank8_sb #(.DATA_WIDTH(16), .ZERO_R0(1'b1)) u_dut_z (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_ready(b_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_be(wb_be), .wb_spurious(b_spur),
        .iss_valid(iss_valid), .iss_dst(iss_dst), .iss_has_dst(iss_has_dst),
        .iss_src_a(iss_src_a), .iss_src_b(iss_src_b), .iss_use_b(iss_use_b),
        .iss_stall(b_stall), .pending(b_pend),
        .r0_out(b_r[0]), .r1_out(b_r[1]), .r2_out(b_r[2]), .r3_out(b_r[3]),
        .r4_out(b_r[4]), .r5_out(b_r[5]), .r6_out(b_r[6]), .r7_out(b_r[7])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic logic [15:0] get_sig(input int sel);
        case (sel)
            0, 1, 2, 3, 4, 5, 6, 7: return a_r[sel];
            S_PEND:    return {8'h00, a_pend};
            S_READY:   return {15'h0, a_ready};
            S_SPUR:    return {15'h0, a_spur};
            S_STALL:   return {15'h0, a_stall};
            S_B_R0:    return b_r[0];
            S_B_PEND:  return {8'h00, b_pend};
            S_B_SPUR:  return {15'h0, b_spur};
            S_B_STALL: return {15'h0, b_stall};
            S_B_RDY:   return {15'h0, b_ready};
            17, 18, 19, 20, 21, 22, 23: return b_r[sel - 16];
            default:   return 16'hxxxx;
        endcase
    endfunction

    // Monitor: compares every expectation due in the current cycle.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].cyc == cyc) begin
                    logic [15:0] act;
                    act = get_sig(q[i].sel);
                    n_checks++;
                    if (act !== q[i].exp) begin
                        n_fail++;
                        $display("FAIL %s (cycle %0d): got 0x%04h expected 0x%04h",
                                 q[i].name, cyc, act, q[i].exp);
                    end
                    q.delete(i);
                end
            end
        end
    end

    task automatic expect_sig(input int dly, input int sel, input logic [15:0] exp,
                              input string name);
        exp_t e;
        e.cyc  = cyc + dly;
        e.sel  = sel;
        e.exp  = exp;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic v, input logic [2:0] a, input logic [15:0] d,
                      input logic [1:0] be);
        wb_valid = v;
        wb_addr  = a;
        wb_data  = d;
        wb_be    = be;
    endtask

    task automatic iss(input logic v, input logic [2:0] dst, input logic hd,
                       input logic [2:0] sa, input logic [2:0] sb, input logic ub);
        iss_valid   = v;
        iss_dst     = dst;
        iss_has_dst = hd;
        iss_src_a   = sa;
        iss_src_b   = sb;
        iss_use_b   = ub;
    endtask

    initial begin
        reset = 1'b1;
        wb(1'b0, 3'd0, 16'h0000, 2'b00);
        iss(1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0);
        tick();
        tick();

        // Out of reset: first cycle not ready, write held until accepted.
        reset = 1'b0;
        wb(1'b1, 3'd3, 16'hBEEF, 2'b11);
        expect_sig(0, S_READY, 16'h0, "ready_first_cycle");
        expect_sig(0, S_PEND,  16'h0, "reset_pending");
        expect_sig(0, 3,       16'h0, "reset_r3");
        expect_sig(0, S_SPUR,  16'h0, "reset_spurious");
        tick();
        expect_sig(0, S_READY, 16'h1, "ready_after");
        expect_sig(0, 3,       16'h0, "r3_not_yet");
        expect_sig(1, 3,       16'hBEEF, "r3_write");
        expect_sig(1, S_SPUR,  16'h1, "spurious_r3");
        expect_sig(1, S_PEND,  16'h0, "pend_after_r3");
        tick();
        n_checks++;
        if (a_r[3] !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL direct_r3_write: got 0x%04h expected 0xBEEF", a_r[3]);
        end
        n_checks++;
        if (a_spur !== 1'b1) begin
            n_fail++;
            $display("FAIL direct_spurious_r3: got %b expected 1", a_spur);
        end
        wb(1'b0, 3'd0, 16'h0000, 2'b00);
        expect_sig(1, S_SPUR, 16'h0, "spurious_one_cycle");

        // Issue dst=r5 then a RAW on r5 that stalls until r5 is written back.
        iss(1'b1, 3'd5, 1'b1, 3'd1, 3'd2, 1'b1);
        expect_sig(0, S_STALL, 16'h0, "issue_r5_free");
        expect_sig(1, S_PEND,  16'h20, "pend_r5");
        tick();
        iss(1'b1, 3'd7, 1'b1, 3'd5, 3'd0, 1'b0);
        expect_sig(0, S_STALL, 16'h1, "raw_stall_1");
        tick();
        expect_sig(0, S_STALL, 16'h1, "raw_stall_2");
        expect_sig(0, S_PEND,  16'h20, "pend_held");
        tick();
        wb(1'b1, 3'd5, 16'h0055, 2'b11);
        expect_sig(0, S_STALL, 16'h0, "stall_released_by_wb");
        expect_sig(1, S_PEND,  16'h80, "pend_r5clr_r7set");
        expect_sig(1, 5,       16'h0055, "r5_write");
        expect_sig(1, S_SPUR,  16'h0, "spurious_r5");
        tick();

        // Same-edge clear and set on r4: set wins.
        wb(1'b0, 3'd0, 16'h0000, 2'b00);
        iss(1'b1, 3'd4, 1'b1, 3'd0, 3'd0, 1'b0);
        expect_sig(1, S_PEND, 16'h90, "pend_r4_set");
        tick();
        wb(1'b1, 3'd4, 16'h4444, 2'b11);
        expect_sig(0, S_STALL, 16'h0, "waw_released_by_wb");
        expect_sig(1, S_PEND,  16'h90, "set_wins");
        expect_sig(1, S_SPUR,  16'h0, "spurious_r4");
        expect_sig(1, 4,       16'h4444, "r4_write");
        tick();

        // Byte lanes on r6.
        iss(1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0);
        wb(1'b1, 3'd6, 16'h1234, 2'b11);
        expect_sig(1, 6,      16'h1234, "r6_full");
        expect_sig(1, S_SPUR, 16'h1, "spurious_r6");
        tick();
        wb(1'b0, 3'd0, 16'h0000, 2'b00);
        iss(1'b1, 3'd6, 1'b1, 3'd0, 3'd0, 1'b0);
        expect_sig(1, S_PEND, 16'hD0, "pend_r6_a");
        tick();
        iss(1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0);
        wb(1'b1, 3'd6, 16'hAB00, 2'b10);
        expect_sig(1, 6,      16'hAB34, "r6_hi_lane");
        expect_sig(1, S_PEND, 16'h90, "pend_r6_clr_a");
        expect_sig(1, S_SPUR, 16'h0, "spurious_r6_hi");
        tick();
        wb(1'b1, 3'd6, 16'h00CD, 2'b01);
        expect_sig(1, 6,      16'hABCD, "r6_lo_lane");
        expect_sig(1, S_SPUR, 16'h1, "spurious_r6_lo");
        tick();
        wb(1'b0, 3'd0, 16'h0000, 2'b00);
        iss(1'b1, 3'd6, 1'b1, 3'd0, 3'd0, 1'b0);
        expect_sig(1, S_PEND, 16'hD0, "pend_r6_b");
        tick();
        iss(1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0);
        wb(1'b1, 3'd6, 16'hFFFF, 2'b00);
        expect_sig(1, 6,      16'hABCD, "r6_no_lane");
        expect_sig(1, S_PEND, 16'h90, "be00_clears_pend");
        expect_sig(1, S_SPUR, 16'h0, "spurious_be00");
        tick();
        n_checks++;
        if (a_r[6] !== 16'hABCD) begin
            n_fail++;
            $display("FAIL direct_r6_no_lane: got 0x%04h expected 0xABCD", a_r[6]);
        end

        // Unused source B and no-destination instructions (r4, r7 pending).
        wb(1'b0, 3'd0, 16'h0000, 2'b00);
        iss(1'b1, 3'd0, 1'b0, 3'd0, 3'd7, 1'b0);
        expect_sig(0, S_STALL, 16'h0, "src_b_unused");
        tick();
        iss(1'b1, 3'd0, 1'b0, 3'd0, 3'd7, 1'b1);
        expect_sig(0, S_STALL, 16'h1, "src_b_used");
        tick();
        iss(1'b1, 3'd4, 1'b0, 3'd0, 3'd0, 1'b0);
        expect_sig(0, S_STALL, 16'h0, "no_dst_no_stall");
        expect_sig(1, S_PEND,  16'h90, "no_dst_pend_same");
        tick();
        iss(1'b1, 3'd4, 1'b1, 3'd0, 3'd0, 1'b0);
        expect_sig(0, S_STALL, 16'h1, "waw_stall");
        tick();

        // Reset mid-operation with a write and an issue presented.
        iss(1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0);
        wb(1'b1, 3'd2, 16'h5555, 2'b11);
        expect_sig(1, 2, 16'h5555, "r2_write");
        tick();
        reset = 1'b1;
        wb(1'b1, 3'd2, 16'hAAAA, 2'b11);
        iss(1'b1, 3'd1, 1'b1, 3'd0, 3'd0, 1'b0);
        expect_sig(1, 2,        16'h0, "rst_r2");
        expect_sig(1, 3,        16'h0, "rst_r3");
        expect_sig(1, 4,        16'h0, "rst_r4");
        expect_sig(1, 5,        16'h0, "rst_r5");
        expect_sig(1, 6,        16'h0, "rst_r6");
        expect_sig(1, S_PEND,   16'h0, "rst_pend");
        expect_sig(1, S_SPUR,   16'h0, "rst_spurious");
        expect_sig(1, S_READY,  16'h0, "rst_ready");
        expect_sig(1, S_B_RDY,  16'h0, "rst_ready_z");
        expect_sig(1, 19,       16'h0, "rst_r3_z");
        tick();
        n_checks++;
        if (a_pend !== 8'h00) begin
            n_fail++;
            $display("FAIL direct_rst_pend: got 0x%02h expected 0x00", a_pend);
        end
        n_checks++;
        if (a_r[2] !== 16'h0000) begin
            n_fail++;
            $display("FAIL direct_rst_r2: got 0x%04h expected 0x0000", a_r[2]);
        end
        reset = 1'b0;
        wb(1'b0, 3'd0, 16'h0000, 2'b00);
        iss(1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0);
        tick();

        // r0 write on both instances: only the non-hardwired one changes.
        expect_sig(0, S_READY, 16'h1, "ready_after_rst");
        wb(1'b1, 3'd0, 16'h1357, 2'b11);
        expect_sig(1, 0,        16'h1357, "r0_write");
        expect_sig(1, S_SPUR,   16'h1, "spurious_r0");
        expect_sig(1, S_B_R0,   16'h0, "z_r0_stays_0");
        expect_sig(1, S_B_SPUR, 16'h0, "z_no_spurious_r0");
        tick();
        wb(1'b0, 3'd0, 16'h0000, 2'b00);
        iss(1'b1, 3'd0, 1'b1, 3'd1, 3'd0, 1'b0);
        expect_sig(0, S_STALL,  16'h0, "issue_r0");
        expect_sig(1, S_PEND,   16'h01, "pend_r0");
        expect_sig(1, S_B_PEND, 16'h00, "z_pend_r0_never");
        tick();
        iss(1'b1, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0);
        expect_sig(0, S_STALL,   16'h1, "raw_r0");
        expect_sig(0, S_B_STALL, 16'h0, "z_no_raw_r0");
        tick();
        iss(1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0);
        tick();
        tick();

        foreach (q[i]) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: never sampled, expected 0x%04h", q[i].name, q[i].exp);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
